// File: rtl/sort_engine.sv
// In-place bubble sorter: stream words in, sort them in a register array, stream them out.
// Optional build macro SORT_EARLY_EXIT_EN ends the sort after the first pass without a swap.
module sort_engine #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 8,
    parameter bit SIGNED = 1'b1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   start,
    input  logic                   descending,
    output logic                   busy,
    output logic                   done,
    output logic [$clog2(DEPTH):0] count,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_last
);

    // state   | meaning
    // IDLE    | accept load beats, wait for start
    // RDA     | reg_a <= mem[j]
    // RDB     | reg_b <= mem[j+1]
    // CMP     | decide swap; pair ends here if no swap
    // WRA     | mem[j]   <= reg_b
    // WRB     | mem[j+1] <= reg_a; pair ends
    // DRAIN   | stream mem[0..n-1] out
    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RDA   = 3'd1;
    localparam logic [2:0] S_RDB   = 3'd2;
    localparam logic [2:0] S_CMP   = 3'd3;
    localparam logic [2:0] S_WRA   = 3'd4;
    localparam logic [2:0] S_WRB   = 3'd5;
    localparam logic [2:0] S_DRAIN = 3'd6;

    localparam logic [AW:0] C_ONE   = (AW+1)'(1);
    localparam logic [AW:0] C_TWO   = (AW+1)'(2);
    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

    logic [2:0]       r_state;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_count;
    logic [AW:0]      r_n;
    logic [AW:0]      r_rd_ptr;
    logic [AW:0]      r_pass;
    logic [AW:0]      r_j;
    logic             r_desc;
    logic             r_done;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
`ifdef SORT_EARLY_EXIT_EN
    logic             r_swapped;
`endif

    logic             w_load;
    logic             w_start;
    logic [AW:0]      w_n_new;
    logic [AW-1:0]    w_j_idx;
    logic [AW-1:0]    w_j1_idx;
    logic [AW-1:0]    w_cnt_idx;
    logic [AW-1:0]    w_rd_idx;
    logic             w_a_gt_b;
    logic             w_b_gt_a;
    logic             w_swap;
    logic             w_pair_end;
    logic             w_pair_last;
    logic             w_pass_last;
    logic             w_early_stop;
    logic             w_sort_end;

    assign in_ready  = (r_state == S_IDLE) && (r_count < C_DEPTH);
    assign w_load    = in_valid && in_ready;
    assign w_start   = start && (r_state == S_IDLE);
    assign w_n_new   = r_count + {{AW{1'b0}}, w_load};

    assign w_j_idx   = r_j[AW-1:0];
    assign w_j1_idx  = w_j_idx + AW'(1);
    assign w_cnt_idx = r_count[AW-1:0];
    assign w_rd_idx  = r_rd_ptr[AW-1:0];

    assign w_a_gt_b  = SIGNED ? ($signed(r_a) > $signed(r_b)) : (r_a > r_b);
    assign w_b_gt_a  = SIGNED ? ($signed(r_b) > $signed(r_a)) : (r_b > r_a);
    // Equal words never swap, which keeps the sort stable.
    assign w_swap    = r_desc ? w_b_gt_a : w_a_gt_b;

    assign w_pair_end  = ((r_state == S_CMP) && !w_swap) || (r_state == S_WRB);
    assign w_pair_last = (r_j == r_n - C_TWO - r_pass);
    assign w_pass_last = (r_pass == r_n - C_TWO);
`ifdef SORT_EARLY_EXIT_EN
    // A pass ending at CMP saw no swap in its last pair; r_swapped covers the rest.
    assign w_early_stop = (r_state == S_CMP) && !r_swapped;
`else
    assign w_early_stop = 1'b0;
`endif
    assign w_sort_end  = w_pair_end && w_pair_last && (w_pass_last || w_early_stop);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_n      <= '0;
            r_rd_ptr <= '0;
            r_pass   <= '0;
            r_j      <= '0;
            r_desc   <= 1'b0;
            r_done   <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
`ifdef SORT_EARLY_EXIT_EN
            r_swapped <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_load) begin
                        r_count <= r_count + C_ONE;
                    end
                    if (w_start) begin
                        r_n      <= w_n_new;
                        r_desc   <= descending;
                        r_pass   <= '0;
                        r_j      <= '0;
                        r_rd_ptr <= '0;
`ifdef SORT_EARLY_EXIT_EN
                        r_swapped <= 1'b0;
`endif
                        if (w_n_new == '0) begin
                            r_done <= 1'b1;
                        end else if (w_n_new == C_ONE) begin
                            r_done  <= 1'b1;
                            r_state <= S_DRAIN;
                        end else begin
                            r_state <= S_RDA;
                        end
                    end
                end
                S_RDA: begin
                    r_a     <= r_mem[w_j_idx];
                    r_state <= S_RDB;
                end
                S_RDB: begin
                    r_b     <= r_mem[w_j1_idx];
                    r_state <= S_CMP;
                end
                S_CMP: begin
                    if (w_swap) begin
                        r_state <= S_WRA;
`ifdef SORT_EARLY_EXIT_EN
                        r_swapped <= 1'b1;
`endif
                    end
                end
                S_WRA: r_state <= S_WRB;
                S_WRB: r_state <= S_RDA;
                S_DRAIN: begin
                    if (out_ready) begin
                        if (r_rd_ptr == r_n - C_ONE) begin
                            r_count  <= '0;
                            r_rd_ptr <= '0;
                            r_state  <= S_IDLE;
                        end else begin
                            r_rd_ptr <= r_rd_ptr + C_ONE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Next pair starts back-to-back; no bubble between pairs or passes.
            if (w_pair_end) begin
                if (w_sort_end) begin
                    r_state  <= S_DRAIN;
                    r_done   <= 1'b1;
                    r_rd_ptr <= '0;
                end else if (w_pair_last) begin
                    r_pass  <= r_pass + C_ONE;
                    r_j     <= '0;
                    r_state <= S_RDA;
`ifdef SORT_EARLY_EXIT_EN
                    r_swapped <= 1'b0;
`endif
                end else begin
                    r_j     <= r_j + C_ONE;
                    r_state <= S_RDA;
                end
            end
        end
    end

    // Storage is not reset; only the write path is held off during reset.
    always_ff @(posedge clk) begin
        if (rstn) begin
            if (w_load) begin
                r_mem[w_cnt_idx] <= in_data;
            end else if (r_state == S_WRA) begin
                r_mem[w_j_idx] <= r_b;
            end else if (r_state == S_WRB) begin
                r_mem[w_j1_idx] <= r_a;
            end
        end
    end

    assign busy      = (r_state == S_RDA) || (r_state == S_RDB) || (r_state == S_CMP) ||
                       (r_state == S_WRA) || (r_state == S_WRB);
    assign done      = r_done;
    assign count     = r_count;
    assign out_valid = (r_state == S_DRAIN);
    assign out_data  = r_mem[w_rd_idx];
    assign out_last  = out_valid && (r_rd_ptr == r_n - C_ONE);

endmodule

// File: tb/tb_sort_engine.sv
// Bench for sort_engine: signed and unsigned instances share stimulus and are checked
// against a queue-based reference of the sorted result and expected busy time.
module tb_sort_engine;

    localparam int AW = 3;
    typedef logic [31:0] wq_t[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, in_valid, start, descending, out_ready;
    logic [31:0] in_data;
    logic [1:0]  in_ready_v, busy_v, done_v, out_valid_v, out_last_v;
    logic [AW:0] count_v [2];
    logic [31:0] out_data_v [2];

    sort_engine #(.WIDTH(32), .DEPTH(8), .SIGNED(1'b1)) u_s (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_v[0]),
        .in_data(in_data), .start(start), .descending(descending), .busy(busy_v[0]),
        .done(done_v[0]), .count(count_v[0]), .out_valid(out_valid_v[0]),
        .out_ready(out_ready), .out_data(out_data_v[0]), .out_last(out_last_v[0]));

    sort_engine #(.WIDTH(32), .DEPTH(8), .SIGNED(1'b0)) u_u (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_v[1]),
        .in_data(in_data), .start(start), .descending(descending), .busy(busy_v[1]),
        .done(done_v[1]), .count(count_v[1]), .out_valid(out_valid_v[1]),
        .out_ready(out_ready), .out_data(out_data_v[1]), .out_last(out_last_v[1]));

    int          n_checks = 0;
    int          n_errors = 0;
    wq_t         loaded;
    wq_t         exp_q [2];
    int          exp_busy [2];
    int          got_busy [2];
    int          got_done [2];
    bit          stalled [2];
    logic [31:0] held [2];
    int          exp_n = 0;
    bit          sgn_of [2] = '{1'b1, 1'b0};

    task automatic chk(input string name, input int k, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s inst=%0d got=%0h exp=%0h t=%0t", name, k, got, exp, $time);
        end
    endtask

    function automatic bit gt(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        return sgn ? ($signed(a) > $signed(b)) : (a > b);
    endfunction

    function automatic wq_t sorted(input wq_t v, input bit sgn, input bit desc);
        wq_t src = v;
        wq_t res;
        while (src.size() > 0) begin
            int best = 0;
            for (int i = 1; i < src.size(); i++)
                if (desc ? gt(src[i], src[best], sgn) : gt(src[best], src[i], sgn)) best = i;
            res.push_back(src[best]);
            src.delete(best);
        end
        return res;
    endfunction

    // Each compared pair costs 3 cycles, 5 when it swaps.
    function automatic int busy_model(input wq_t v, input bit sgn, input bit desc);
        int cyc = 0;
        int n = v.size();
        for (int p = 0; p <= n - 2; p++) begin
            bit sw = 1'b0;
            for (int j = 0; j <= n - 2 - p; j++) begin
                bit s = desc ? gt(v[j+1], v[j], sgn) : gt(v[j], v[j+1], sgn);
                cyc += s ? 5 : 3;
                if (s) begin
                    logic [31:0] t = v[j];
                    v[j] = v[j+1];
                    v[j+1] = t;
                    sw = 1'b1;
                end
            end
`ifdef SORT_EARLY_EXIT_EN
            if (!sw) break;
`endif
        end
        return cyc;
    endfunction

    always @(negedge clk) begin
        if (rstn) begin
            for (int k = 0; k < 2; k++) begin
                if (busy_v[k]) begin
                    got_busy[k]++;
                    chk("in_ready_while_busy", k, in_ready_v[k], 0);
                end
                if (done_v[k]) begin
                    got_done[k]++;
                    chk("out_valid_at_done", k, out_valid_v[k], exp_n != 0);
                end
                if (out_valid_v[k]) begin
                    if (exp_q[k].size() == 0) begin
                        chk("spurious_beat", k, out_valid_v[k], 0);
                    end else begin
                        chk("out_data", k, out_data_v[k], exp_q[k][0]);
                        chk("out_last", k, out_last_v[k], exp_q[k].size() == 1);
                        if (stalled[k]) chk("stall_hold", k, out_data_v[k], held[k]);
                        stalled[k] = !out_ready;
                        held[k] = out_data_v[k];
                        if (out_ready) void'(exp_q[k].pop_front());
                    end
                end else begin
                    stalled[k] = 1'b0;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] v);
        if ($urandom_range(0, 2) == 0) cyc();
        chk("in_ready_load", 0, in_ready_v[0], 1);
        chk("in_ready_load", 1, in_ready_v[1], 1);
        in_valid = 1'b1;
        in_data  = v;
        loaded.push_back(v);
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic do_start(input bit desc, input bit with_beat, input logic [31:0] bv);
        if (with_beat) begin
            in_valid = 1'b1;
            in_data  = bv;
            loaded.push_back(bv);
        end
        start = 1'b1;
        descending = desc;
        exp_n = loaded.size();
        for (int k = 0; k < 2; k++) begin
            exp_q[k]    = sorted(loaded, sgn_of[k], desc);
            exp_busy[k] = busy_model(loaded, sgn_of[k], desc);
            got_busy[k] = 0;
            got_done[k] = 0;
            stalled[k]  = 1'b0;
        end
        cyc();
        start = 1'b0;
        in_valid = 1'b0;
        descending = ($urandom_range(0, 1) == 1);
        loaded.delete();
    endtask

    task automatic drain(input int mode);
        int dc = 0;
        bit seen = 1'b0;
        bit fin = 1'b0;
        for (int t = 0; t < 3000 && !fin; t++) begin
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = !(seen && dc >= 2 && dc < 5);
            endcase
            cyc();
            if (out_valid_v[0]) seen = 1'b1;
            if (seen) dc++;
            fin = (exp_q[0].size() == 0) && (exp_q[1].size() == 0) &&
                  (got_done[0] > 0) && (got_done[1] > 0);
        end
        out_ready = 1'b0;
        if (!fin) chk("drain_timeout", 0, 0, 1);
        for (int k = 0; k < 2; k++) begin
            chk("done_once", k, got_done[k], 1);
            chk("busy_cycles", k, got_busy[k], exp_busy[k]);
            chk("count_after", k, count_v[k], 0);
            chk("in_ready_after", k, in_ready_v[k], 1);
        end
    endtask

    task automatic chk_count(input int n);
        chk("count_loaded", 0, count_v[0], n);
        chk("count_loaded", 1, count_v[1], n);
    endtask

    initial begin
        logic [31:0] lit [4];
        rstn = 1'b0; in_valid = 1'b0; start = 1'b0; descending = 1'b0;
        out_ready = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_in_ready", k, in_ready_v[k], 1);
            chk("rst_busy", k, busy_v[k], 0);
            chk("rst_done", k, done_v[k], 0);
            chk("rst_count", k, count_v[k], 0);
            chk("rst_out_valid", k, out_valid_v[k], 0);
            chk("rst_out_last", k, out_last_v[k], 0);
        end
        cyc();

        // basic ascending
        load(32'd5); load(32'd3); load(32'd8); load(32'd1);
        chk_count(4);
        do_start(1'b0, 1'b0, '0);
        lit = '{32'd1, 32'd3, 32'd5, 32'd8};
        for (int i = 0; i < 4; i++) chk("pin_t1", 0, exp_q[0][i], lit[i]);
        drain(0);

        // signed descending, then unsigned ascending of the same words
        load(32'hFFFFFFFE); load(32'd7); load(32'd0); load(32'hFFFFFFF7);
        do_start(1'b1, 1'b0, '0);
        lit = '{32'd7, 32'd0, 32'hFFFFFFFE, 32'hFFFFFFF7};
        for (int i = 0; i < 4; i++) chk("pin_t2_signed", 0, exp_q[0][i], lit[i]);
        drain(1);
        load(32'hFFFFFFFE); load(32'd7); load(32'd0); load(32'hFFFFFFF7);
        do_start(1'b0, 1'b0, '0);
        lit = '{32'd0, 32'd7, 32'hFFFFFFF7, 32'hFFFFFFFE};
        for (int i = 0; i < 4; i++) chk("pin_t2_unsigned", 1, exp_q[1][i], lit[i]);
        drain(1);

        // full, reversed, ninth beat held off
        for (int v = 8; v >= 1; v--) load(32'(v));
        in_valid = 1'b1; in_data = 32'd9;
        for (int i = 0; i < 3; i++) begin
            chk("full_in_ready", 0, in_ready_v[0], 0);
            cyc();
        end
        in_valid = 1'b0;
        chk_count(8);
        do_start(1'b0, 1'b0, '0);
        chk("pin_busy_140", 0, exp_busy[0], 140);
        drain(0);

        // already sorted
        for (int v = 1; v <= 8; v++) load(32'(v));
        do_start(1'b0, 1'b0, '0);
`ifdef SORT_EARLY_EXIT_EN
        chk("pin_busy_sorted", 0, exp_busy[0], 21);
`else
        chk("pin_busy_sorted", 0, exp_busy[0], 84);
`endif
        chk("pin_sorted_last", 0, exp_q[0][7], 8);
        drain(0);

        // mid-stream stall
        for (int i = 0; i < 6; i++) load($urandom);
        do_start(1'b1, 1'b0, '0);
        drain(2);

        // empty and single-element sorts
        do_start(1'b0, 1'b0, '0);
        drain(0);
        load(32'd42);
        do_start(1'b1, 1'b0, '0);
        drain(2);

        // reset while sorting
        load(32'd4); load(32'd2); load(32'd9); load(32'd1);
        do_start(1'b0, 1'b0, '0);
        repeat (4) cyc();
        chk("busy_before_rst", 0, busy_v[0], 1);
        rstn = 1'b0;
        exp_q[0].delete(); exp_q[1].delete();
        cyc();
        for (int k = 0; k < 2; k++) begin
            chk("midrst_busy", k, busy_v[k], 0);
            chk("midrst_count", k, count_v[k], 0);
            chk("midrst_in_ready", k, in_ready_v[k], 1);
            chk("midrst_out_valid", k, out_valid_v[k], 0);
        end
        rstn = 1'b1;
        cyc();

        // randomized runs
        for (int r = 0; r < 12; r++) begin
            int n = $urandom_range(0, 8);
            bit wb;
            for (int i = 0; i < n; i++) begin
                int sv = int'($urandom_range(0, 6)) - 3;
                load(($urandom_range(0, 1) == 1) ? $urandom : sv);
            end
            chk_count(n);
            wb = (n < 8) && ($urandom_range(0, 1) == 1);
            do_start($urandom_range(0, 1) == 1, wb, $urandom);
            drain(1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
